// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//
// Contents:
//   state_e       - FSM state encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   SA_WIDTH_DEF  - default operand / sum width in bits
//
// Optional feature macro used elsewhere in this slice: SERIAL_ADDER_OVF_EN
// (adds the signed-overflow flag to the interface and the adder).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   // Default operand width used when the parent does not override WIDTH.
   localparam int SA_WIDTH_DEF = 8;

   // The encoding is fixed so that state values seen in a waveform match the
   // values teammates already know from the block's documentation.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Request / result bundle between a client and the bit-serial adder.
//
// Parameters:
//   WIDTH  - operand and sum width in bits (>= 2)
//
// Signals:
//   start  client -> adder  request, only honoured while the adder is idle
//   a, b   client -> adder  operands, captured on the accepting edge
//   cin    client -> adder  carry-in, captured on the accepting edge
//   busy   adder -> client  high while bits are being added
//   done   adder -> client  one-cycle pulse, sum/cout valid
//   sum    adder -> client  result, held until the next accepted start
//   cout   adder -> client  final carry-out, held with sum
//   ovf    adder -> client  signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Modports:
//   master - the requesting client
//   slave  - the adder
// -----------------------------------------------------------------------------
import serial_adder_pkg::*;

interface serial_adder_if #(
   parameter int WIDTH = SA_WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   // The overflow flag only exists when the feature is built in, so the
   // modport lists come in two complete flavours.
`ifdef SERIAL_ADDER_OVF_EN
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
`else
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
`endif

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full-adder cell used as the arithmetic core of the serial adder.
//
// Ports:
//   a, b  input   operand bits
//   ci    input   carry in
//   s     output  sum bit
//   co    output  carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Classic propagate/generate form: the carry comes out either because
   // both operands are set, or because one of them propagates the carry-in.
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds
// them LSB-first through a single full_adder cell over WIDTH clock cycles.
// The carry flop feeds the cell's carry-out back as the next carry-in.
//
// Parameters:
//   WIDTH  - operand and sum width in bits (>= 2)
//
// Ports:
//   clk    input   system clock, all state changes on the rising edge
//   rst    input   synchronous, active-high reset
//   bus    slave   serial_adder_if (start/a/b/cin in, busy/done/sum/cout out)
//
// Configuration macro:
//   SERIAL_ADDER_OVF_EN - when defined, a signed overflow flag is produced on
//                         bus.ovf and held alongside sum/cout.
// -----------------------------------------------------------------------------
import serial_adder_pkg::*;

module serial_adder #(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   // The last step is the one where the counter already holds WIDTH-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           stateQ;
   logic [WIDTH-1:0] opAQ;
   logic [WIDTH-1:0] opBQ;
   logic             carryQ;
   logic [WIDTH-1:0] sumQ;
   logic [CNT_W-1:0] cntQ;
   logic             busyQ;
   logic             doneQ;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovfQ;
`endif

   logic             cellS;
   logic             cellCo;
   logic [WIDTH-1:0] sumD;
   logic [WIDTH-1:0] opAD;
   logic [WIDTH-1:0] opBD;
   logic [CNT_W-1:0] cntD;
   logic             lastStep;

   // One cell evaluates the current bit pair every cycle; its inputs come
   // straight from the shift-register LSBs and the carry flop.
   full_adder uCell (
      .a  (opAQ[0]),
      .b  (opBQ[0]),
      .ci (carryQ),
      .s  (cellS),
      .co (cellCo)
   );

   // Next values for one SHIFT step. The sum fills from the MSB side so that
   // after WIDTH steps the first bit produced has landed in bit 0.
   always_comb begin
      sumD     = {cellS, sumQ[WIDTH-1:1]};
      opAD     = {1'b0, opAQ[WIDTH-1:1]};
      opBD     = {1'b0, opBQ[WIDTH-1:1]};
      cntD     = cntQ + CNT_W'(1);
      lastStep = (cntQ == CNT_LAST);
   end

   // Control FSM and datapath registers in one block. busy and done are
   // registered so that they change on the same edges as the state itself.
   // Reset wins over everything, including a start on the same edge, and an
   // operation interrupted by reset never produces a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= ST_IDLE;
         opAQ   <= '0;
         opBQ   <= '0;
         carryQ <= 1'b0;
         sumQ   <= '0;
         cntQ   <= '0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovfQ   <= 1'b0;
`endif
      end else begin
         case (stateQ)
            ST_IDLE: begin
               doneQ <= 1'b0;
               if (bus.start) begin
                  opAQ   <= bus.a;
                  opBQ   <= bus.b;
                  carryQ <= bus.cin;
                  sumQ   <= '0;
                  cntQ   <= '0;
                  busyQ  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                  ovfQ   <= 1'b0;
`endif
                  stateQ <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               sumQ   <= sumD;
               carryQ <= cellCo;
               opAQ   <= opAD;
               opBQ   <= opBD;
               cntQ   <= cntD;
               if (lastStep) begin
                  // On the MSB step carryQ is the carry into the sign bit and
                  // cellCo the carry out of it; differing means overflow.
`ifdef SERIAL_ADDER_OVF_EN
                  ovfQ   <= carryQ ^ cellCo;
`endif
                  busyQ  <= 1'b0;
                  doneQ  <= 1'b1;
                  stateQ <= ST_DONE;
               end
            end

            ST_DONE: begin
               doneQ  <= 1'b0;
               stateQ <= ST_IDLE;
            end

            default: begin
               busyQ  <= 1'b0;
               doneQ  <= 1'b0;
               stateQ <= ST_IDLE;
            end
         endcase
      end
   end

   // After the last step the carry flop holds the final carry-out, and it is
   // left alone until the next accepted start reloads it with cin.
   assign bus.busy = busyQ;
   assign bus.done = doneQ;
   assign bus.sum  = sumQ;
   assign bus.cout = carryQ;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovfQ;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH = 8). A cycle-level reference
// model derived from the handshake timing and plain integer addition runs
// alongside the DUT; directed operations additionally pin literal results.
// Builds with or without SERIAL_ADDER_OVF_EN.
// -----------------------------------------------------------------------------
import serial_adder_pkg::*;

module tb_serial_adder;

   localparam int W = 8;

   logic clk;
   logic rst;

   int compared   = 0;
   int mismatched = 0;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single place where comparisons are counted and failures reported.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Reference model. Works purely from edge counts: an operation accepted at
   // edge e shows busy for W cycles, done in the cycle after edge e+W, and the
   // adder can accept again from edge e+W+2. The result is ordinary integer
   // addition of the captured operands.
   int            edgeCnt  = 0;
   int            acceptAt = -1;
   logic [W:0]    modelRes = '0;
`ifdef SERIAL_ADDER_OVF_EN
   logic          modelOvf = 1'b0;
`endif

   initial begin
      forever begin
         @(posedge clk);
         edgeCnt++;
         if (rst) begin
            acceptAt = -1;
            modelRes = '0;
`ifdef SERIAL_ADDER_OVF_EN
            modelOvf = 1'b0;
`endif
         end else if (bus.start && (acceptAt < 0 || edgeCnt - acceptAt >= W + 2)) begin
            acceptAt = edgeCnt;
            modelRes = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
`ifdef SERIAL_ADDER_OVF_EN
            begin
               int sa;
               int sb;
               int st;
               sa = int'($signed(bus.a));
               sb = int'($signed(bus.b));
               st = sa + sb + int'(bus.cin);
               modelOvf = (st > (2 ** (W - 1)) - 1) || (st < -(2 ** (W - 1)));
            end
`endif
         end
         #1;
         begin
            int  t;
            bit  expBusy;
            bit  expDone;
            bit  resValid;
            t        = edgeCnt - acceptAt;
            expBusy  = (acceptAt >= 0) && (t < W);
            expDone  = (acceptAt >= 0) && (t == W);
            resValid = (acceptAt < 0) || (t >= W);
            checkOutput("busy", 32'(bus.busy), 32'(expBusy));
            checkOutput("done", 32'(bus.done), 32'(expDone));
            if (resValid) begin
               checkOutput("sum", 32'(bus.sum), 32'(modelRes[W-1:0]));
               checkOutput("cout", 32'(bus.cout), 32'(modelRes[W]));
`ifdef SERIAL_ADDER_OVF_EN
               checkOutput("ovf", 32'(bus.ovf), 32'(modelOvf));
`endif
            end
         end
      end
   end

   // Pulse start for one cycle with the given operands. Two negedges first so
   // that, when called right after a done cycle, start lands in IDLE. Returns
   // between the accepting edge and the next one, operands scrambled.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic cv);
      @(negedge clk);
      @(negedge clk);
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = cv;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
   endtask

   // Wait (bounded) for done; edges counts rising edges until it is visible.
   task automatic waitDone(output int edges);
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         edges++;
         if (bus.done) break;
      end
      if (!bus.done) checkOutput("doneTimeout", 32'(bus.done), 32'd1);
   endtask

   // Count done pulses over a window, to prove none appear.
   task automatic countDone(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #2;
         if (bus.done) pulses++;
      end
   endtask

   initial begin
      int edges;
      int pulses;
      int lastDone;
      int cyc;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstDone", 32'(bus.done), 32'd0);
      checkOutput("rstSum", 32'(bus.sum), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 0x5A + 0x33: busy for W cycles, then done with 0x8D.
      applyStimulus(8'h5A, 8'h33, 1'b0);
      #2;
      checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
      waitDone(edges);
      checkOutput("busyCycles", 32'(edges), 32'(W));
      checkOutput("sum5A33", 32'(bus.sum), 32'h8D);
      checkOutput("cout5A33", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("ovf5A33", 32'(bus.ovf), 32'd1);
`endif

      // 0xFF + 0x01: wraps to 0 with carry-out; done is captured by a
      // consumer on the ninth edge after the accepting edge.
      applyStimulus(8'hFF, 8'h01, 1'b0);
      waitDone(edges);
      checkOutput("doneSampleEdge", 32'(edges + 1), 32'(W + 1));
      checkOutput("sumFF01", 32'(bus.sum), 32'h00);
      checkOutput("coutFF01", 32'(bus.cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("ovfFF01", 32'(bus.ovf), 32'd0);
`endif

      // Carry-in alone, then the all-ones extreme.
      applyStimulus(8'h00, 8'h00, 1'b1);
      waitDone(edges);
      checkOutput("sumCinOnly", 32'(bus.sum), 32'h01);
      checkOutput("coutCinOnly", 32'(bus.cout), 32'd0);
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      waitDone(edges);
      checkOutput("sumAllOnes", 32'(bus.sum), 32'hFF);
      checkOutput("coutAllOnes", 32'(bus.cout), 32'd1);

      // A second start during SHIFT must be ignored and not queued.
      applyStimulus(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      bus.a     = 8'hFF;
      bus.b     = 8'hFF;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(edges);
      checkOutput("sumIgnored", 32'(bus.sum), 32'h30);
      checkOutput("coutIgnored", 32'(bus.cout), 32'd0);
      countDone(14, pulses);
      checkOutput("singleDone", 32'(pulses), 32'd0);

      // Reset on the 4th SHIFT cycle aborts without a done pulse.
      applyStimulus(8'h5A, 8'h33, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("abortBusy", 32'(bus.busy), 32'd0);
      checkOutput("abortSum", 32'(bus.sum), 32'd0);
      checkOutput("abortCout", 32'(bus.cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      countDone(14, pulses);
      checkOutput("abortNoDone", 32'(pulses), 32'd0);
      applyStimulus(8'h21, 8'h42, 1'b0);
      waitDone(edges);
      checkOutput("sumAfterAbort", 32'(bus.sum), 32'h63);

      // start held high: a new operation every W+2 cycles, each giving 2.
      repeat (3) @(negedge clk);
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      pulses   = 0;
      lastDone = -1;
      for (cyc = 1; cyc <= 35; cyc++) begin
         @(posedge clk);
         #2;
         if (bus.done) begin
            pulses++;
            checkOutput("heldSum", 32'(bus.sum), 32'h02);
            if (lastDone >= 0) checkOutput("heldPeriod", 32'(cyc - lastDone), 32'(W + 2));
            lastDone = cyc;
         end
      end
      checkOutput("heldPulses", 32'(pulses), 32'd3);
      @(negedge clk);
      bus.start = 1'b0;

      // Random traffic with occasional resets; the model checks every cycle.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, 2) != 0);
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
         bus.cin   = 1'($urandom);
         rst       = ($urandom_range(0, 79) == 0);
      end
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (W + 4) @(posedge clk);
      #3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_serial_adder
